// File: rtl/ball_sprite_engine.sv
// rtl/ball_sprite_engine.sv - square sprite position, bounce/manual motion and registered colour
module ball_sprite_engine #(
    parameter int          H_RES     = 1280,
    parameter int          V_RES     = 720,
    parameter int          COORD_W   = 16,
    parameter int          BALL_SIZE = 10,
    parameter int          STEP      = 2,
    parameter logic [11:0] FG_COLOR  = 12'hFFF,
    parameter logic [11:0] BG_COLOR  = 12'h00F
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               mode,
    input  logic               up,
    input  logic               down,
    input  logic               left,
    input  logic               right,
    input  logic               center,
    input  logic [COORD_W-1:0] x_coord,
    input  logic [COORD_W-1:0] y_coord,
    output logic [11:0]        color_o,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic               bounce_hit
);

    typedef logic signed [COORD_W:0] scoord_t;

    typedef struct packed {
        logic [COORD_W-1:0] pos;
        logic               flag;
        logic               hit;
    } axis_t;

    localparam scoord_t            X_MAX_S = scoord_t'(H_RES - BALL_SIZE);
    localparam scoord_t            Y_MAX_S = scoord_t'(V_RES - BALL_SIZE);
    localparam scoord_t            STEP_S  = scoord_t'(STEP);
    localparam scoord_t            ZERO_S  = '0;
    localparam logic [COORD_W-1:0] X_CEN   = COORD_W'((H_RES - BALL_SIZE) / 2);
    localparam logic [COORD_W-1:0] Y_CEN   = COORD_W'((V_RES - BALL_SIZE) / 2);
    localparam logic [COORD_W:0]   SIZE_M1 = (COORD_W + 1)'(BALL_SIZE - 1);

    logic  dx_pos;
    logic  dy_pos;
    logic  center_q;
    logic  pending;
    logic  center_rise;
    logic  render_hit;
    axis_t bx;
    axis_t by;
    logic [COORD_W-1:0] mx;
    logic [COORD_W-1:0] my;

    // One step in the flagged direction, clamped to the playfield; clamping is a reflection.
    function automatic axis_t bounce_axis(input logic [COORD_W-1:0] pos,
                                          input logic flag,
                                          input scoord_t max_s);
        scoord_t cand;
        axis_t   r;
        cand   = flag ? ($signed({1'b0, pos}) + STEP_S) : ($signed({1'b0, pos}) - STEP_S);
        r.pos  = cand[COORD_W-1:0];
        r.flag = flag;
        r.hit  = 1'b0;
        if (cand < ZERO_S) begin
            r.pos  = '0;
            r.flag = 1'b1;
            r.hit  = 1'b1;
        end else if (cand > max_s) begin
            r.pos  = max_s[COORD_W-1:0];
            r.flag = 1'b0;
            r.hit  = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [COORD_W-1:0] manual_axis(input logic [COORD_W-1:0] pos,
                                                      input logic dec,
                                                      input logic inc,
                                                      input scoord_t max_s);
        scoord_t cand;
        cand = $signed({1'b0, pos});
        if (dec && !inc) begin
            cand = cand - STEP_S;
            if (cand < ZERO_S) cand = ZERO_S;
        end else if (inc && !dec) begin
            cand = cand + STEP_S;
            if (cand > max_s) cand = max_s;
        end
        return cand[COORD_W-1:0];
    endfunction

    always_comb begin
        bx          = bounce_axis(ball_x, dx_pos, X_MAX_S);
        by          = bounce_axis(ball_y, dy_pos, Y_MAX_S);
        mx          = manual_axis(ball_x, left, right, X_MAX_S);
        my          = manual_axis(ball_y, up, down, Y_MAX_S);
        center_rise = center && !center_q;
    end

    // Widened compare so the window end never wraps near the coordinate limit.
    always_comb begin
        render_hit = ({1'b0, x_coord} >= {1'b0, ball_x}) &&
                     ({1'b0, x_coord} <= ({1'b0, ball_x} + SIZE_M1)) &&
                     ({1'b0, y_coord} >= {1'b0, ball_y}) &&
                     ({1'b0, y_coord} <= ({1'b0, ball_y} + SIZE_M1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ball_x     <= X_CEN;
            ball_y     <= Y_CEN;
            dx_pos     <= 1'b1;
            dy_pos     <= 1'b1;
            color_o    <= 12'h000;
            bounce_hit <= 1'b0;
            pending    <= 1'b0;
            center_q   <= 1'b0;
        end else begin
            center_q   <= center;
            color_o    <= render_hit ? FG_COLOR : BG_COLOR;
            bounce_hit <= 1'b0;
            if (frame_tick) begin
                if (pending) begin
                    ball_x <= X_CEN;
                    ball_y <= Y_CEN;
                end else if (mode) begin
                    ball_x     <= bx.pos;
                    ball_y     <= by.pos;
                    dx_pos     <= bx.flag;
                    dy_pos     <= by.flag;
                    bounce_hit <= bx.hit || by.hit;
                end else begin
                    ball_x <= mx;
                    ball_y <= my;
                end
            end
            // A new press on a tick cycle is held for the following tick.
            if (center_rise) begin
                pending <= 1'b1;
            end else if (frame_tick) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ball_sprite_engine.sv
// tb/tb_ball_sprite_engine.sv - scoreboard bench with a behavioural sprite model
module tb_ball_sprite_engine;

    localparam int H_RES = 1280;
    localparam int V_RES = 720;
    localparam int BSZ   = 10;
    localparam int STEP  = 2;
    localparam int XMAX  = H_RES - BSZ;
    localparam int YMAX  = V_RES - BSZ;
    localparam int XCEN  = 635;
    localparam int YCEN  = 355;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        mode = 1'b0;
    logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, center = 1'b0;
    logic [15:0] x_coord = '0, y_coord = '0;
    logic [11:0] color_o;
    logic [15:0] ball_x, ball_y;
    logic        bounce_hit;

    ball_sprite_engine dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .mode(mode),
        .up(up), .down(down), .left(left), .right(right), .center(center),
        .x_coord(x_coord), .y_coord(y_coord), .color_o(color_o),
        .ball_x(ball_x), .ball_y(ball_y), .bounce_hit(bounce_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] c;
        int          x;
        int          y;
        logic        h;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    int   m_x, m_y;
    bit   m_dx, m_dy, m_pend, m_cprev;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
        end
    endtask

    task automatic model_reset();
        m_x = XCEN; m_y = YCEN; m_dx = 1; m_dy = 1; m_pend = 0; m_cprev = 0;
    endtask

    // Bounce on one axis: returns 1 when the step overshoots and gets clamped.
    function automatic bit bounce(inout int p, inout bit pos_dir, input int maxv);
        int cand = pos_dir ? p + STEP : p - STEP;
        if (cand < 0) begin p = 0; pos_dir = 1; return 1; end
        if (cand > maxv) begin p = maxv; pos_dir = 0; return 1; end
        p = cand;
        return 0;
    endfunction

    function automatic int manual(input int p, input bit dec, input bit inc, input int maxv);
        if (dec && !inc) return (p - STEP < 0) ? 0 : p - STEP;
        if (inc && !dec) return (p + STEP > maxv) ? maxv : p + STEP;
        return p;
    endfunction

    task automatic cycle(input bit t, input bit m, input bit u, input bit d, input bit l,
                         input bit r, input bit c, input int xc, input int yc);
        exp_t e;
        bit   rise, refl;
        @(negedge clk);
        #1;
        frame_tick = t; mode = m; up = u; down = d; left = l; right = r; center = c;
        x_coord = 16'(xc); y_coord = 16'(yc);
        e.c  = (xc >= m_x && xc < m_x + BSZ && yc >= m_y && yc < m_y + BSZ) ? 12'hFFF : 12'h00F;
        rise = c && !m_cprev;
        m_cprev = c;
        refl = 0;
        if (t) begin
            if (m_pend) begin
                m_x = XCEN; m_y = YCEN; m_pend = 0;
            end else if (m) begin
                refl = bounce(m_x, m_dx, XMAX);
                refl = bounce(m_y, m_dy, YMAX) | refl;
            end else begin
                m_x = manual(m_x, l, r, XMAX);
                m_y = manual(m_y, u, d, YMAX);
            end
        end
        if (rise) m_pend = 1;
        e.x = m_x; e.y = m_y; e.h = refl;
        sb.push_back(e);
    endtask

    task automatic settle();
        #8;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_color", int'(color_o), int'(e.c));
                check("sb_ball_x", int'(ball_x), e.x);
                check("sb_ball_y", int'(ball_y), e.y);
                check("sb_bounce_hit", int'(bounce_hit), int'(e.h));
            end
        end
    end

    initial begin : stim
        int hits;
        int xc, yc;
        bit t, cc;
        model_reset();
        x_coord = 16'd635; y_coord = 16'd355;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ball_x", int'(ball_x), 635);
        check("rst_ball_y", int'(ball_y), 355);
        check("rst_color", int'(color_o), 12'h000);
        check("rst_bounce_hit", int'(bounce_hit), 0);
        rst_n = 1'b1;

        cycle(0, 0, 0, 0, 0, 0, 0, 635, 355); settle(); check("win_origin", int'(color_o), 12'hFFF);
        cycle(0, 0, 0, 0, 0, 0, 0, 644, 364); settle(); check("win_corner", int'(color_o), 12'hFFF);
        cycle(0, 0, 0, 0, 0, 0, 0, 645, 355); settle(); check("win_right_out", int'(color_o), 12'h00F);
        cycle(0, 0, 0, 0, 0, 0, 0, 634, 355); settle(); check("win_left_out", int'(color_o), 12'h00F);

        repeat (3) cycle(1, 0, 0, 0, 0, 1, 0, 0, 0);
        settle(); check("manual_right3", int'(ball_x), 641);
        cycle(1, 0, 1, 1, 0, 0, 0, 0, 0);
        settle(); check("manual_updown", int'(ball_y), 355);

        cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 1, 0, 0, 0);
        settle(); check("recentre_x", int'(ball_x), 635);
        check("recentre_y", int'(ball_y), 355);

        repeat (317) cycle(1, 0, 0, 0, 1, 0, 0, 0, 0);
        settle(); check("manual_left_at1", int'(ball_x), 1);
        repeat (3) cycle(1, 0, 0, 0, 1, 0, 0, 0, 0);
        settle(); check("manual_left_clamp", int'(ball_x), 0);

        // Long bounce run: covers both edges and corner-adjacent reflections on both axes.
        hits = 0;
        repeat (1400) begin
            cycle(1, 1, $urandom_range(0, 1), 0, 0, $urandom_range(0, 1), 0, 0, 0);
            if (sb[$].h) hits++;
        end
        check("bounce_reflections_seen", int'(hits > 4), 1);

        cc = 0;
        repeat (3000) begin
            t = ($urandom_range(0, 3) == 0);
            if (!t && $urandom_range(0, 30) == 0) cc = ~cc;
            if ($urandom_range(0, 1) == 1) begin
                xc = m_x - 2 + int'($urandom_range(0, BSZ + 3));
                yc = m_y - 2 + int'($urandom_range(0, BSZ + 3));
                if (xc < 0) xc = 0;
                if (yc < 0) yc = 0;
            end else begin
                xc = int'($urandom_range(0, H_RES - 1));
                yc = int'($urandom_range(0, V_RES - 1));
            end
            cycle(t, ($urandom_range(0, 7) != 0) ? mode : ~mode, $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), cc, xc, yc);
        end

        // Reset mid-frame in bounce mode with a recentre pending.
        repeat (5) cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        center = 1'b0;
        model_reset();
        #1;
        check("async_rst_x", int'(ball_x), 635);
        check("async_rst_y", int'(ball_y), 355);
        check("async_rst_color", int'(color_o), 12'h000);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1, 1, 0, 0, 0, 0, 0, 640, 360);
        settle(); check("post_rst_tick_x", int'(ball_x), 637);
        check("post_rst_tick_y", int'(ball_y), 357);
        check("post_rst_no_hit", int'(bounce_hit), 0);
        repeat (20) cycle(1, 1, 0, 0, 0, 0, 0, 640, 360);

        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
